// File: rtl/message_composer_if.sv
// Bundles the keyboard, receive, transmit and screen-text signals of the
// message composer. The composer uses the slave modport; its environment
// (keyboard decoder, laser TX/RX, text layout) uses master.
interface message_composer_if #(
  parameter int NLINES = 5,
  parameter int NCHAR  = 16
);
  localparam int LW = NCHAR * 8;
  localparam int HW = LW * NLINES;

  logic          key_valid;
  logic [7:0]    key_ascii;
  logic          rx_valid;
  logic [LW-1:0] rx_line;
  logic          tx_ready;
  logic          tx_valid;
  logic [LW-1:0] tx_data;
  logic [LW-1:0] keyboard;
  logic [HW-1:0] messageout;
  logic [HW-1:0] messagein;

  modport master (
    output key_valid, key_ascii, rx_valid, rx_line, tx_ready,
    input  tx_valid, tx_data, keyboard, messageout, messagein
  );

  modport slave (
    input  key_valid, key_ascii, rx_valid, rx_line, tx_ready,
    output tx_valid, tx_data, keyboard, messageout, messagein
  );
endinterface

// File: rtl/message_composer.sv
// Chat text builder: assembles typed characters into a right-justified
// keyboard line, commits finished lines to the outgoing history and the
// laser transmitter, and scrolls received lines into the incoming history.
module message_composer #(
  parameter int NLINES = 5,
  parameter int NCHAR  = 16
) (
  input  logic clock_65mhz,
  input  logic reset,
  message_composer_if.slave bus
);
  localparam int LW = NCHAR * 8;
  localparam int HW = LW * NLINES;
  localparam int CW = $clog2(NCHAR + 1);

  localparam logic [LW-1:0] BLANK_LINE = {NCHAR{8'h20}};
  localparam logic [HW-1:0] BLANK_HIST = {(NLINES * NCHAR){8'h20}};
  localparam logic [CW-1:0] FULL       = CW'(NCHAR);

  localparam logic [7:0] KEY_BS    = 8'h08;
  localparam logic [7:0] KEY_ENTER = 8'h0D;

  typedef enum logic {IDLE, SEND} tx_state_t;

  tx_state_t     state;
  logic [CW-1:0] count;
  logic          tx_valid_q;
  logic [LW-1:0] tx_data_q;
  logic [LW-1:0] keyboard_q;
  logic [HW-1:0] messageout_q;
  logic [HW-1:0] messagein_q;

  logic printable;
  assign printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);

  // Key decode, commit, TX handshake and receive scroll, all on one edge.
  // The handshake test reads the pre-edge state, so an Enter arriving in the
  // same cycle as tx_ready while in SEND is dropped rather than committed.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= BLANK_LINE;
      keyboard_q   <= BLANK_LINE;
      messageout_q <= BLANK_HIST;
      messagein_q  <= BLANK_HIST;
    end else begin
      if (state == SEND && bus.tx_ready) begin
        state      <= IDLE;
        tx_valid_q <= 1'b0;
      end

      if (bus.key_valid) begin
        if (printable) begin
          if (count < FULL) begin
            keyboard_q <= {keyboard_q[LW-9:0], bus.key_ascii};
            count      <= count + 1'b1;
          end
        end else if (bus.key_ascii == KEY_BS) begin
          if (count != '0) begin
            keyboard_q <= {8'h20, keyboard_q[LW-1:8]};
            count      <= count - 1'b1;
          end
        end else if (bus.key_ascii == KEY_ENTER) begin
          if (count != '0 && state == IDLE) begin
            tx_data_q    <= keyboard_q;
            messageout_q <= {keyboard_q, messageout_q[HW-1:LW]};
            keyboard_q   <= BLANK_LINE;
            count        <= '0;
            state        <= SEND;
            tx_valid_q   <= 1'b1;
          end
        end
      end

      if (bus.rx_valid) begin
        messagein_q <= {bus.rx_line, messagein_q[HW-1:LW]};
      end
    end
  end

  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.keyboard   = keyboard_q;
  assign bus.messageout = messageout_q;
  assign bus.messagein  = messagein_q;
endmodule

// File: tb/tb_message_composer.sv
// Directed bench for message_composer: typing, overflow, backspace, commit
// with TX handshake, ignored Enters, receive scrolling and async reset.
module tb_message_composer;
  localparam logic [127:0] BL = {16{8'h20}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  message_composer_if #(.NLINES(5), .NCHAR(16)) bus ();

  message_composer #(.NLINES(5), .NCHAR(16)) dut (
    .clock_65mhz(clk),
    .reset      (rst),
    .bus        (bus)
  );

  // Strobe one key for one cycle; consecutive calls give back-to-back strobes.
  task automatic press(input logic [7:0] c);
    bus.key_valid = 1'b1;
    bus.key_ascii = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
  endtask

  task automatic test_reset;
    bus.key_valid = 1'b0; bus.key_ascii = 8'h00;
    bus.rx_valid = 1'b0;  bus.rx_line = '0;
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL reset_keyboard got=%h exp=%h", bus.keyboard, BL); end
    checks++; if (bus.tx_data !== BL) begin errors++; $display("FAIL reset_tx_data got=%h exp=%h", bus.tx_data, BL); end
    checks++; if (bus.messageout !== {5{BL}}) begin errors++; $display("FAIL reset_messageout got=%h", bus.messageout); end
    checks++; if (bus.messagein !== {5{BL}}) begin errors++; $display("FAIL reset_messagein got=%h", bus.messagein); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_typing;
    press(8'h48); press(8'h49);
    checks++; if (bus.keyboard !== {{14{8'h20}}, 16'h4849}) begin errors++; $display("FAIL type_hi got=%h", bus.keyboard); end
    press(8'h07); press(8'h7F);
    checks++; if (bus.keyboard !== {{14{8'h20}}, 16'h4849}) begin errors++; $display("FAIL nonprint_ignored got=%h", bus.keyboard); end
    press(8'h08); press(8'h08);
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL bs_to_empty got=%h", bus.keyboard); end
    press(8'h08);
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL bs_at_empty got=%h", bus.keyboard); end
    press(8'h41);
    checks++; if (bus.keyboard !== {{15{8'h20}}, 8'h41}) begin errors++; $display("FAIL count_after_bs_empty got=%h", bus.keyboard); end
    press(8'h08);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) press(8'h41);
    checks++; if (bus.keyboard !== {16{8'h41}}) begin errors++; $display("FAIL overflow_full got=%h", bus.keyboard); end
    press(8'h08);
    checks++; if (bus.keyboard !== {8'h20, {15{8'h41}}}) begin errors++; $display("FAIL overflow_bs got=%h", bus.keyboard); end
    press(8'h42);
    checks++; if (bus.keyboard !== {{15{8'h41}}, 8'h42}) begin errors++; $display("FAIL refill_after_bs got=%h", bus.keyboard); end
    for (int i = 0; i < 16; i++) press(8'h08);
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL overflow_clear got=%h", bus.keyboard); end
  endtask

  task automatic test_commit;
    press(8'h48); press(8'h49); press(8'h0D);
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL commit_tx_valid got=%b exp=1", bus.tx_valid); end
    checks++; if (bus.tx_data !== {{14{8'h20}}, 16'h4849}) begin errors++; $display("FAIL commit_tx_data got=%h", bus.tx_data); end
    checks++; if (bus.messageout[527:512] !== 16'h4849) begin errors++; $display("FAIL commit_msgout_line4 got=%h exp=4849", bus.messageout[527:512]); end
    checks++; if (bus.messageout !== {{{14{8'h20}}, 16'h4849}, {4{BL}}}) begin errors++; $display("FAIL commit_msgout got=%h", bus.messageout); end
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL commit_keyboard_blank got=%h", bus.keyboard); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL tx_hold cycle=%0d got=%b exp=1", i, bus.tx_valid); end
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_handshake got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL ready_in_idle got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_ignored_enter;
    logic [127:0] hi, ab, cd;
    hi = {{14{8'h20}}, 16'h4849};
    ab = {{14{8'h20}}, 16'h4142};
    cd = {{14{8'h20}}, 16'h4344};
    press(8'h41); press(8'h42); press(8'h0D);
    checks++; if (bus.messageout !== {ab, hi, {3{BL}}}) begin errors++; $display("FAIL second_commit got=%h", bus.messageout); end
    press(8'h43); press(8'h44); press(8'h0D);
    checks++; if (bus.messageout !== {ab, hi, {3{BL}}}) begin errors++; $display("FAIL enter_in_send_scroll got=%h", bus.messageout); end
    checks++; if (bus.tx_data !== ab) begin errors++; $display("FAIL enter_in_send_tx_data got=%h exp=%h", bus.tx_data, ab); end
    checks++; if (bus.keyboard !== cd) begin errors++; $display("FAIL enter_in_send_kb got=%h exp=%h", bus.keyboard, cd); end
    bus.tx_ready = 1'b1;
    press(8'h0D);
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL enter_with_ready_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.messageout !== {ab, hi, {3{BL}}}) begin errors++; $display("FAIL enter_with_ready_scroll got=%h", bus.messageout); end
    checks++; if (bus.keyboard !== cd) begin errors++; $display("FAIL enter_with_ready_kb got=%h exp=%h", bus.keyboard, cd); end
    press(8'h08); press(8'h08); press(8'h0D);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL empty_enter_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.messageout !== {ab, hi, {3{BL}}}) begin errors++; $display("FAIL empty_enter_scroll got=%h", bus.messageout); end
    checks++; if (bus.tx_data !== ab) begin errors++; $display("FAIL empty_enter_tx_data got=%h exp=%h", bus.tx_data, ab); end
  endtask

  task automatic test_rx_and_simultaneous;
    logic [127:0] hi, ab, zl;
    hi = {{14{8'h20}}, 16'h4849};
    ab = {{14{8'h20}}, 16'h4142};
    zl = {{15{8'h20}}, 8'h5A};
    for (int i = 1; i <= 6; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_line  = {16{8'(8'h60 + i)}};
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.messagein !== {{16{8'h66}}, {16{8'h65}}, {16{8'h64}}, {16{8'h63}}, {16{8'h62}}}) begin
      errors++; $display("FAIL rx_six_lines got=%h", bus.messagein);
    end
    press(8'h5A);
    bus.rx_valid = 1'b1;
    bus.rx_line  = {16{8'h67}};
    press(8'h0D);
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.messagein !== {{16{8'h67}}, {16{8'h66}}, {16{8'h65}}, {16{8'h64}}, {16{8'h63}}}) begin
      errors++; $display("FAIL simul_messagein got=%h", bus.messagein);
    end
    checks++; if (bus.messageout !== {zl, ab, hi, {2{BL}}}) begin errors++; $display("FAIL simul_messageout got=%h", bus.messageout); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL simul_tx_valid got=%b exp=1", bus.tx_valid); end
    checks++; if (bus.tx_data !== zl) begin errors++; $display("FAIL simul_tx_data got=%h exp=%h", bus.tx_data, zl); end
  endtask

  task automatic test_reset_mid_send;
    press(8'h51);
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", bus.tx_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.keyboard !== BL) begin errors++; $display("FAIL async_reset_kb got=%h", bus.keyboard); end
    checks++; if (bus.messageout !== {5{BL}}) begin errors++; $display("FAIL async_reset_msgout got=%h", bus.messageout); end
    checks++; if (bus.messagein !== {5{BL}}) begin errors++; $display("FAIL async_reset_msgin got=%h", bus.messagein); end
    checks++; if (bus.tx_data !== BL) begin errors++; $display("FAIL async_reset_tx_data got=%h", bus.tx_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_typing;
    test_overflow;
    test_commit;
    test_ignored_enter;
    test_rx_and_simultaneous;
    test_reset_mid_send;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
